// File: rtl/vdp_cpu_port.sv
// VDP CPU port: synchronizes Z80 strobes, runs the control-word latch, the
// auto-incrementing address and read-ahead buffer, and sequences VRAM/CRAM/register access.
module vdp_cpu_port #(
  parameter int ADDR_W      = 14,
  parameter int CRAM_AW     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               csr_l,
  input  logic               csw_l,
  input  logic               mode,
  input  logic [7:0]         dataIn,
  output logic [7:0]         dataOut,
  input  logic [7:0]         status_in,
  output logic               status_clr,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               vram_req,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]         cram_wdata,
  output logic               cram_we,
  output logic               reg_we,
  output logic [3:0]         reg_num,
  output logic [7:0]         reg_data,
  output logic               busy
);
  localparam int L = SYNC_STAGES - 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic [1:0] {EV_DW = 2'b00, EV_CW = 2'b01, EV_DR = 2'b10, EV_CR = 2'b11} ev_t;

  logic [SYNC_STAGES-1:0]      r_csr_s, r_csw_s, r_mode_s;
  logic [SYNC_STAGES-1:0][7:0] r_din_s;
  logic                        r_csr_d, r_csw_d;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_code;
  logic               r_first;
  logic [7:0]         r_buf;
  logic               r_rd_first;
  logic               r_pend_vld;
  ev_t                r_pend_type;
  logic [7:0]         r_pend_data;

  logic               w_wr_fall, w_rd_fall, w_ev_vld;
  ev_t                w_ev_type, w_x_type;
  logic [7:0]         w_x_data;
  logic               w_exec, w_rahead, w_ack;
  logic [ADDR_W-1:0]  w_ra_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_csr_s  <= '1;
      r_csw_s  <= '1;
      r_mode_s <= '0;
      r_din_s  <= '0;
      r_csr_d  <= 1'b1;
      r_csw_d  <= 1'b1;
    end else begin
      r_csr_s  <= {r_csr_s[SYNC_STAGES-2:0], csr_l};
      r_csw_s  <= {r_csw_s[SYNC_STAGES-2:0], csw_l};
      r_mode_s <= {r_mode_s[SYNC_STAGES-2:0], mode};
      r_din_s  <= {r_din_s[SYNC_STAGES-2:0], dataIn};
      r_csr_d  <= r_csr_s[L];
      r_csw_d  <= r_csw_s[L];
    end
  end

  // A simultaneous read and write collapses into the write.
  assign w_wr_fall = r_csw_d & ~r_csw_s[L];
  assign w_rd_fall = r_csr_d & ~r_csr_s[L];
  assign w_ev_vld  = w_wr_fall | w_rd_fall;
  assign w_ev_type = ev_t'({~w_wr_fall, r_mode_s[L]});

  // In IDLE the pending slot has priority over a live event.
  assign w_exec    = (r_state == IDLE) & (r_pend_vld | w_ev_vld);
  assign w_x_type  = r_pend_vld ? r_pend_type : w_ev_type;
  assign w_x_data  = r_pend_vld ? r_pend_data : r_din_s[L];
  assign w_rahead  = w_exec & ((w_x_type == EV_DR) |
                     ((w_x_type == EV_CW) & r_first & (w_x_data[7:6] == 2'd0)));
  assign w_ra_addr = (w_x_type == EV_DR) ? r_addr : {w_x_data[ADDR_W-9:0], r_addr[7:0]};
  assign busy      = (r_state == RD_WAIT);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    case (r_state)
      IDLE:    if (w_rahead) w_state_nxt = RD_WAIT;
      RD_WAIT: begin
        w_ack = vram_ack & ~r_rd_first;
        if (w_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_code      <= '0;
      r_first     <= 1'b0;
      r_buf       <= '0;
      r_rd_first  <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_type <= EV_DW;
      r_pend_data <= '0;
      dataOut     <= '0;
      status_clr  <= 1'b0;
      vram_addr   <= '0;
      vram_wdata  <= '0;
      vram_we     <= 1'b0;
      vram_req    <= 1'b0;
      cram_addr   <= '0;
      cram_wdata  <= '0;
      cram_we     <= 1'b0;
      reg_we      <= 1'b0;
      reg_num     <= '0;
      reg_data    <= '0;
    end else begin
      status_clr <= 1'b0;
      vram_we    <= 1'b0;
      cram_we    <= 1'b0;
      reg_we     <= 1'b0;
      r_rd_first <= 1'b0;

      if (r_state == IDLE) begin
        r_pend_vld <= r_pend_vld & w_ev_vld;
        if (r_pend_vld & w_ev_vld) begin
          r_pend_type <= w_ev_type;
          r_pend_data <= r_din_s[L];
        end
      end else if (w_ev_vld & ~r_pend_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_type <= w_ev_type;
        r_pend_data <= r_din_s[L];
      end

      if (w_ack) begin
        r_buf    <= vram_rdata;
        vram_req <= 1'b0;
      end

      if (w_exec) begin
        case (w_x_type)
          EV_CW: begin
            if (!r_first) begin
              r_addr[7:0] <= w_x_data;
              r_first     <= 1'b1;
            end else begin
              r_code               <= w_x_data[7:6];
              r_addr[ADDR_W-1:8]   <= w_x_data[ADDR_W-9:0];
              r_first              <= 1'b0;
              if (w_x_data[7:6] == 2'd2) begin
                reg_we   <= 1'b1;
                reg_num  <= w_x_data[3:0];
                reg_data <= r_addr[7:0];
              end
            end
          end
          EV_DW: begin
            r_first <= 1'b0;
            r_buf   <= w_x_data;
            if (r_code == 2'd3) begin
              cram_we    <= 1'b1;
              cram_addr  <= r_addr[CRAM_AW-1:0];
              cram_wdata <= w_x_data;
            end else begin
              vram_we    <= 1'b1;
              vram_addr  <= r_addr;
              vram_wdata <= w_x_data;
            end
            r_addr <= r_addr + ADDR_W'(1);
          end
          EV_DR: begin
            r_first <= 1'b0;
            dataOut <= r_buf;
          end
          EV_CR: begin
            r_first    <= 1'b0;
            dataOut    <= status_in;
            status_clr <= 1'b1;
          end
          default: ;
        endcase
      end

      // The first RD_WAIT cycle ignores ack: it cannot belong to this request.
      if (w_rahead) begin
        vram_addr  <= w_ra_addr;
        vram_req   <= 1'b1;
        r_rd_first <= 1'b1;
        r_addr     <= w_ra_addr + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed scenarios plus random CPU traffic, checked
// against an event-level model of the port (address/code/latch/buffer rules).
module tb_vdp_cpu_port;
  localparam int AW = 14;
  localparam int K_VWE = 0, K_CWE = 1, K_REG = 2, K_REQ = 3, K_SCLR = 4;

  logic clock = 0, reset = 1;
  logic csr_l = 1, csw_l = 1, mode = 0;
  logic [7:0] dataIn = 0, status_in = 0, dataOut, reg_data, vram_wdata, cram_wdata;
  logic [7:0] vram_rdata;
  logic status_clr, vram_we, vram_req, vram_ack, cram_we, reg_we, busy;
  logic [AW-1:0] vram_addr;
  logic [4:0] cram_addr;
  logic [3:0] reg_num;

  vdp_cpu_port dut (
    .clock(clock), .reset(reset), .csr_l(csr_l), .csw_l(csw_l), .mode(mode),
    .dataIn(dataIn), .dataOut(dataOut), .status_in(status_in), .status_clr(status_clr),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_req(vram_req),
    .vram_ack(vram_ack), .vram_rdata(vram_rdata), .cram_addr(cram_addr),
    .cram_wdata(cram_wdata), .cram_we(cram_we), .reg_we(reg_we), .reg_num(reg_num),
    .reg_data(reg_data), .busy(busy));

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cyc = 0, t_fall = 0, last_we_cyc = 0;
  int ack_dly = 4;
  bit ack_en = 1, mon_en = 0, req_d = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int k, input int a, input int d);
    return {k[7:0], a[15:0], d[7:0]};
  endfunction

  // Environment VRAM (written by the DUT) and the model's own copy.
  logic [7:0] mem  [0:(1<<AW)-1];
  logic [7:0] mmem [0:(1<<AW)-1];
  logic [31:0] exp_q[$];

  int m_addr, m_code, m_buf, m_out;
  bit m_first;

  always @(posedge clock) cyc++;

  // Memory responder: ack ack_dly clocks after a request is seen.
  initial begin
    vram_ack = 0; vram_rdata = 0;
    forever begin
      @(negedge clock);
      if (vram_req && ack_en) begin
        repeat (ack_dly - 1) @(negedge clock);
        if (vram_req) begin
          vram_ack = 1; vram_rdata = mem[vram_addr];
          @(negedge clock);
          vram_ack = 0;
        end
      end
    end
  end

  task automatic got(input int k, input int a, input int d);
    logic [31:0] e;
    if (exp_q.size() == 0) chk("spurious_event", pk(k, a, d), 32'hFFFFFFFF);
    else begin
      e = exp_q.pop_front();
      chk("event", pk(k, a, d), e);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (vram_we) begin
        chk("we_while_req", {31'd0, vram_req}, 0);
        got(K_VWE, int'(vram_addr), int'(vram_wdata));
        mem[vram_addr] = vram_wdata;
        last_we_cyc = cyc;
      end
      if (cram_we)    got(K_CWE, int'(cram_addr), int'(cram_wdata));
      if (reg_we)     got(K_REG, int'(reg_num), int'(reg_data));
      if (status_clr) got(K_SCLR, 0, 0);
      if (vram_req && !req_d) got(K_REQ, int'(vram_addr), 0);
    end
    req_d = vram_req;
  end

  task automatic model_reset();
    m_addr = 0; m_code = 0; m_buf = 0; m_out = 0; m_first = 0;
  endtask

  task automatic ra();
    exp_q.push_back(pk(K_REQ, m_addr, 0));
    m_buf  = int'(mmem[m_addr]);
    m_addr = (m_addr + 1) % (1 << AW);
  endtask

  task automatic model_op(input bit rd, input bit md, input int d, input int st);
    if (!rd && md) begin
      if (!m_first) begin
        m_addr = (m_addr & 'h3F00) | d; m_first = 1;
      end else begin
        m_code = d / 64; m_addr = ((d % 64) * 256) | (m_addr % 256); m_first = 0;
        if (m_code == 0) ra();
        if (m_code == 2) exp_q.push_back(pk(K_REG, d % 16, m_addr % 256));
      end
    end else if (!rd) begin
      m_first = 0; m_buf = d;
      if (m_code == 3) exp_q.push_back(pk(K_CWE, m_addr % 32, d));
      else begin
        exp_q.push_back(pk(K_VWE, m_addr, d));
        mmem[m_addr] = d[7:0];
      end
      m_addr = (m_addr + 1) % (1 << AW);
    end else if (!md) begin
      m_first = 0; m_out = m_buf; ra();
    end else begin
      m_first = 0; m_out = st; exp_q.push_back(pk(K_SCLR, 0, 0));
    end
  endtask

  task automatic cpu_op(input bit rd, input bit md, input logic [7:0] d);
    @(posedge clock); #1;
    mode = md; dataIn = d;
    if (rd) csr_l = 0; else csw_l = 0;
    t_fall = cyc;
    repeat (4) @(posedge clock);
    #1; csr_l = 1; csw_l = 1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic op(input bit rd, input bit md, input logic [7:0] d);
    model_op(rd, md, int'(d), int'(status_in));
    cpu_op(rd, md, d);
    if (rd) chk(md ? "dataOut_status" : "dataOut_data", {24'd0, dataOut}, m_out);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin @(posedge clock); #1; n++; end
    chk("idle_timeout", {31'd0, busy}, 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'($urandom);
      mmem[i] = mem[i];
    end
    model_reset();
    repeat (4) @(posedge clock);
    #1;
    chk("rst_dataOut", {24'd0, dataOut}, 0);
    chk("rst_strobes", {27'd0, vram_we, vram_req, cram_we, reg_we, status_clr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_vaddr", {18'd0, vram_addr}, 0);
    reset = 0;
    mon_en = 1;
    repeat (2) @(posedge clock);

    // VRAM write at a latched address, with strobe-to-action latency.
    op(0, 1, 8'h34); op(0, 1, 8'h52);
    op(0, 0, 8'hAB);
    chk("write_latency", last_we_cyc - t_fall, 3);
    op(0, 0, 8'hCD);

    // Register write uses the already latched low byte.
    op(0, 1, 8'h07); op(0, 1, 8'h81);

    // Read-ahead then data read returning the buffered byte.
    mem[14'h3F00] = 8'h5A; mmem[14'h3F00] = 8'h5A; ack_dly = 4;
    op(0, 1, 8'h00); op(0, 1, 8'h3F); wait_idle();
    op(1, 0, 8'h00); wait_idle();
    chk("readahead_data", {24'd0, dataOut}, 32'h5A);

    // CRAM wraps at 32 entries.
    op(0, 1, 8'h1F); op(0, 1, 8'hC0);
    op(0, 0, 8'h11); op(0, 0, 8'h22);

    // Status read clears the first-byte latch.
    op(0, 1, 8'hFF);
    status_in = 8'h80; op(1, 1, 8'h00);
    op(0, 1, 8'h00); op(0, 1, 8'h81);

    // Write arriving during a slow read-ahead at 0x3FFF executes at 0x0000.
    ack_dly = 10;
    op(0, 1, 8'hFF); op(0, 1, 8'h3F);
    chk("busy_rd_wait", {31'd0, busy}, 1);
    op(0, 0, 8'h99);
    wait_idle();
    chk("wrap_write", {24'd0, mem[0]}, 32'h99);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      bit rd, md;
      logic [7:0] d;
      rd = 1'($urandom); md = 1'($urandom); d = 8'($urandom);
      status_in = 8'($urandom);
      ack_dly = $urandom_range(2, 6);
      op(rd, md, d);
      wait_idle();
    end

    // Reset in RD_WAIT drops the request next cycle.
    ack_en = 0;
    op(0, 1, 8'h00); op(0, 1, 8'h10);
    chk("req_before_rst", {31'd0, vram_req}, 1);
    reset = 1;
    @(posedge clock); #1;
    chk("req_after_rst", {31'd0, vram_req}, 0);
    chk("busy_after_rst", {31'd0, busy}, 0);
    reset = 0; model_reset(); ack_en = 1; ack_dly = 3;
    @(posedge clock); #1;
    op(1, 0, 8'h00); wait_idle();

    repeat (5) @(posedge clock);
    chk("events_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
- CPU-side port controller for the VDP; runs in the clk100 domain.
- Decodes Z80 read/write strobes on the VDP data and control ports.
- Runs the two-byte control-word latch, owns the auto-incrementing VRAM/CRAM address and the read-ahead buffer.
- Sequences all CPU-originated VRAM, CRAM and VDP-register accesses; the VDP render pipeline sees only simple request/strobe interfaces.

Parameters:
ADDR_W, 14, VRAM address width (16 KB)
CRAM_AW, 5, CRAM address width (32 entries)
SYNC_STAGES, 2, synchronizer depth on csr_l/csw_l/mode/dataIn (min 2)

Ports:
clock  in  1  clk100 domain clock
reset  in  1  synchronous, active-high reset
csr_l  in  1  CPU read strobe, active low, cpuClk domain
csw_l  in  1  CPU write strobe, active low, cpuClk domain
mode  in  1  0 = data port, 1 = control port
dataIn  in  8  CPU write data
dataOut  out  8  CPU read data, held until next read
status_in  in  8  VDP status byte
status_clr  out  1  1-cycle pulse: status read
vram_addr  out  ADDR_W  VRAM access address
vram_wdata  out  8  VRAM write data
vram_we  out  1  1-cycle VRAM write strobe
vram_req  out  1  VRAM read request, held until ack
vram_ack  in  1  read data valid on vram_rdata this cycle
vram_rdata  in  8  VRAM read data
cram_addr  out  CRAM_AW  CRAM write address
cram_wdata  out  8  CRAM write data
cram_we  out  1  1-cycle CRAM write strobe
reg_we  out  1  1-cycle VDP register write strobe
reg_num  out  4  register index
reg_data  out  8  register value
busy  out  1  high in RD_WAIT

Behaviour:
- Reset: all outputs 0; addr=0, code=0, first_done=0, buffer=0, FSM=IDLE, no pending event.
- Inputs pass through SYNC_STAGES flops. A falling edge of synced csr_l or csw_l is one event; mode and dataIn are sampled on the same synced cycle.
- Event latency: action occurs SYNC_STAGES+1 clocks after the raw strobe edge.
- Both strobes falling in the same cycle: write processed, read ignored.
- FSM IDLE, events:
  - Control write, first_done=0: addr[7:0]<=dataIn; first_done<=1.
  - Control write, first_done=1: code<=dataIn[7:6]; addr[13:8]<=dataIn[5:0]; first_done<=0. Then by code:
    - code 0: issue read-ahead (see below).
    - code 1 or 3: no access.
    - code 2: reg_we pulse with reg_num=dataIn[3:0], reg_data=addr[7:0] (the low byte already latched).
  - Data write: first_done<=0; buffer<=dataIn.
    - code 3: cram_we pulse, cram_addr=addr[4:0], cram_wdata=dataIn.
    - Any other code: vram_we pulse, vram_addr=addr, vram_wdata=dataIn.
    - Then addr<=addr+1.
  - Data read: first_done<=0; dataOut<=buffer; issue read-ahead.
  - Control read: dataOut<=status_in; status_clr pulse; first_done<=0.
- Read-ahead:
  - vram_addr<=addr; vram_req<=1; addr<=addr+1; FSM->RD_WAIT.
  - On vram_ack: buffer<=vram_rdata; vram_req<=0; FSM->IDLE.
  - ack in the same cycle the request is raised is ignored.
- RD_WAIT, new events: one event (type plus data) is captured into a 1-deep pending slot and executed the cycle after the return to IDLE. A second event while the slot is full is dropped.
- Address arithmetic: modulo 2^ADDR_W, so 0x3FFF+1 -> 0x0000. CRAM uses addr[4:0] only, so CRAM wraps at 32 while addr keeps counting.
- reset asserted mid-RD_WAIT: vram_req drops the next cycle; the pending slot is cleared.

Test Plan:
- Control write 0x34 then 0x52 (code 1, addr 0x1234); data write 0xAB -> vram_we once, vram_addr=0x1234, vram_wdata=0xAB; addr becomes 0x1235.
- Control write 0x07 then 0x81 -> reg_we one cycle, reg_num=1, reg_data=0x07; no VRAM/CRAM strobe.
- Control write 0x00 then 0x3F (code 0, addr 0x3F00) -> vram_req at 0x3F00; ack with 0x5A after 4 clocks; data read -> dataOut=0x5A, new vram_req at 0x3F01.
- Control write 0x1F then 0xC0 (code 3); two data writes 0x11, 0x22 -> cram_we at cram_addr 0x1F then 0x00.
- Control write 0xFF (first byte only); control read with status_in=0x80 -> dataOut=0x80, status_clr pulse; next control write 0x00 is treated as first byte again.
- Code-0 read-ahead at 0x3FFF with ack delayed 10 clocks; data write 0x99 arrives during RD_WAIT -> busy=1; after ack, write executes at 0x0000 (wrapped); vram_we is never asserted while vram_req=1.
